uart_frame_receiver: RTL and testbench

//   Parametrised asynchronous serial receiver for the instrument link; successor to the

---
 rtl/uart_frame_receiver_if.sv | 22 ++
 rtl/uart_frame_receiver.sv | 192 +++++++++++++++++++
 tb/tb_uart_frame_receiver.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_receiver_if.sv
// Serial receiver link: raw serial line in, received payload and status strobes out.
// The master side is the receiver itself; the slave side is the line driver/consumer.
interface uart_frame_receiver_if #(
  parameter int DATA_BITS = 22
);
  logic                 serial_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 busy;
  logic                 framing_error;
  logic                 parity_error;

  modport master (
    input  serial_in,
    output data_out, data_valid, busy, framing_error, parity_error
  );

  modport slave (
    output serial_in,
    input  data_out, data_valid, busy, framing_error, parity_error
  );
endinterface

// File: rtl/uart_frame_receiver.sv
// Asynchronous serial frame receiver: 2-flop synchroniser, mid-bit sampling, start-glitch
// rejection, optional parity, stop-bit check and a one-cycle data_valid strobe.
module uart_frame_receiver #(
  parameter int CLKS_PER_BIT = 2606,
  parameter int DATA_BITS    = 22,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input logic                   clock,
  input logic                   reset_n,
  uart_frame_receiver_if.master uart
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic              PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 busy_q, busy_d;
  logic                 framing_error_q, framing_error_d;
  logic                 parity_error_q, parity_error_d;

  logic rx;
  logic stop_ferr;
  logic baud_done;

  assign rx        = sync_q[1];
  assign baud_done = (baud_q == BIT_LAST);
  assign stop_ferr = ferr_acc_q | ~rx;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d         = state_q;
    sync_d          = {sync_q[0], uart.serial_in};
    baud_d          = baud_q;
    bit_idx_d       = bit_idx_q;
    stop_idx_d      = stop_idx_q;
    shift_d         = shift_q;
    perr_acc_d      = perr_acc_q;
    ferr_acc_d      = ferr_acc_q;
    data_out_d      = data_out_q;
    data_valid_d    = 1'b0;
    busy_d          = busy_q;
    framing_error_d = framing_error_q;
    parity_error_d  = parity_error_q;

    unique case (state_q)
      S_IDLE: begin
        if (!rx) begin
          state_d   = S_START;
          baud_d    = '0;
          bit_idx_d = '0;
        end
      end

      // A start bit that is high again at its midpoint is treated as line noise.
      S_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          if (!rx) begin
            state_d    = S_DATA;
            busy_d     = 1'b1;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_done) begin
          baud_d             = '0;
          shift_d[bit_idx_q] = rx;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (baud_done) begin
          baud_d     = '0;
          perr_acc_d = ((^shift_q) ^ rx) != PAR_ODD;
          state_d    = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      // Leaving for IDLE at the stop-bit midpoint lets the next start edge land early.
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (stop_idx_q == STOP_LAST) begin
            stop_idx_d      = 1'b0;
            data_out_d      = shift_q;
            framing_error_d = stop_ferr;
            parity_error_d  = (PARITY_EN != 0) ? perr_acc_q : 1'b0;
            data_valid_d    = 1'b1;
            busy_d          = 1'b0;
            state_d         = stop_ferr ? S_WAIT_IDLE : S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
            ferr_acc_d = stop_ferr;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        if (rx) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      sync_q          <= 2'b11;
      baud_q          <= '0;
      bit_idx_q       <= '0;
      stop_idx_q      <= 1'b0;
      shift_q         <= '0;
      perr_acc_q      <= 1'b0;
      ferr_acc_q      <= 1'b0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      sync_q          <= sync_d;
      baud_q          <= baud_d;
      bit_idx_q       <= bit_idx_d;
      stop_idx_q      <= stop_idx_d;
      shift_q         <= shift_d;
      perr_acc_q      <= perr_acc_d;
      ferr_acc_q      <= ferr_acc_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      busy_q          <= busy_d;
      framing_error_q <= framing_error_d;
      parity_error_q  <= parity_error_d;
    end
  end

  assign uart.data_out      = data_out_q;
  assign uart.data_valid    = data_valid_q;
  assign uart.busy          = busy_q;
  assign uart.framing_error = framing_error_q;
  assign uart.parity_error  = parity_error_q;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver: four configurations share one clock and reset,
// each with its own serial line; a negedge monitor records strobes, busy time and captures.
module tb_uart_frame_receiver;

  localparam int C    = 16;
  localparam int HALF = C / 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] ser = '1;
  int         cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // 0: 8N1   1: 8E1   2: 22N1   3: 22N2
  uart_frame_receiver_if #(.DATA_BITS(8))  if8   ();
  uart_frame_receiver_if #(.DATA_BITS(8))  ifp   ();
  uart_frame_receiver_if #(.DATA_BITS(22)) if22  ();
  uart_frame_receiver_if #(.DATA_BITS(22)) if22s ();

  assign if8.serial_in   = ser[0];
  assign ifp.serial_in   = ser[1];
  assign if22.serial_in  = ser[2];
  assign if22s.serial_in = ser[3];

  uart_frame_receiver #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_8n1 (.clock(clock), .reset_n(reset_n), .uart(if8));
  uart_frame_receiver #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_8e1 (.clock(clock), .reset_n(reset_n), .uart(ifp));
  uart_frame_receiver #(.CLKS_PER_BIT(C), .DATA_BITS(22), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_22n1 (.clock(clock), .reset_n(reset_n), .uart(if22));
  uart_frame_receiver #(.CLKS_PER_BIT(C), .DATA_BITS(22), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_22n2 (.clock(clock), .reset_n(reset_n), .uart(if22s));

  int n_tests = 0;
  int n_fail  = 0;

  int          strobes[4]    = '{default: 0};
  int          busy_hi[4]    = '{default: 0};
  int          strobe_cyc[4] = '{default: 0};
  int          dbl[4]        = '{default: 0};
  int          silent[4]     = '{default: 0};
  logic [31:0] cap_data[4]   = '{default: '0};
  logic [31:0] prev_data[4]  = '{default: '0};
  logic        cap_fe[4]     = '{default: 1'b0};
  logic        cap_pe[4]     = '{default: 1'b0};
  logic        prev_dv[4]    = '{default: 1'b0};
  int          start_cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon(input int k, input logic dv, input logic bsy, input logic [31:0] data,
                     input logic fe, input logic pe);
    if (dv) begin
      strobes[k]++;
      strobe_cyc[k] = cyc;
      cap_data[k]   = data;
      cap_fe[k]     = fe;
      cap_pe[k]     = pe;
      if (prev_dv[k]) dbl[k]++;
    end
    if (bsy) busy_hi[k]++;
    if (reset_n && !dv && data != prev_data[k]) silent[k]++;
    prev_dv[k]   = dv;
    prev_data[k] = data;
  endtask

  always @(negedge clock) begin
    mon(0, if8.data_valid,   if8.busy,   32'(if8.data_out),   if8.framing_error,   if8.parity_error);
    mon(1, ifp.data_valid,   ifp.busy,   32'(ifp.data_out),   ifp.framing_error,   ifp.parity_error);
    mon(2, if22.data_valid,  if22.busy,  32'(if22.data_out),  if22.framing_error,  if22.parity_error);
    mon(3, if22s.data_valid, if22s.busy, 32'(if22s.data_out), if22s.framing_error, if22s.parity_error);
  end

  task automatic drive(input int d, input logic b, input int n);
    ser[d] = b;
    repeat (n) @(negedge clock);
  endtask

  // par < 0 means no parity bit; all stop bits are high except the last, which is last_stop.
  task automatic send_frame(input int d, input logic [31:0] payload, input int nbits, input int par,
                            input int nstop, input logic last_stop, input int stop_len);
    start_cyc = cyc;
    drive(d, 1'b0, C);
    for (int i = 0; i < nbits; i++) drive(d, payload[i], C);
    if (par >= 0) drive(d, 1'(par), C);
    for (int i = 0; i < nstop - 1; i++) drive(d, 1'b1, C);
    drive(d, last_stop, stop_len);
    ser[d] = 1'b1;
  endtask

  int sb, bb;
  logic [31:0] db;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_data",  32'(if8.data_out), 32'h0);
    check("rst_valid", 32'(if8.data_valid), 32'h0);
    check("rst_busy",  32'(if8.busy), 32'h0);
    check("rst_ferr",  32'(if8.framing_error), 32'h0);
    check("rst_perr",  32'(ifp.parity_error), 32'h0);
    check("rst_data22", 32'(if22s.data_out), 32'h0);
    reset_n = 1'b1;
    repeat (2 * C) @(negedge clock);

    // 8N1 0xA5: latency HALF + 9*C + 3 = 155, busy high for 9*C = 144 cycles
    sb = strobes[0]; bb = busy_hi[0];
    send_frame(0, 32'hA5, 8, -1, 1, 1'b1, C);
    check("a5_strobes", 32'(strobes[0] - sb), 32'd1);
    check("a5_data",    cap_data[0], 32'hA5);
    check("a5_ferr",    32'(cap_fe[0]), 32'h0);
    check("a5_perr",    32'(cap_pe[0]), 32'h0);
    check("a5_latency", 32'(strobe_cyc[0] - start_cyc), 32'd155);
    check("a5_busy",    32'(busy_hi[0] - bb), 32'd144);
    check("a5_dv_low",  32'(if8.data_valid), 32'h0);

    // next start edge 12 clocks into the stop bit must still be accepted
    sb = strobes[0];
    send_frame(0, 32'hC3, 8, -1, 1, 1'b1, 12);
    check("c3_data", cap_data[0], 32'hC3);
    send_frame(0, 32'h0F, 8, -1, 1, 1'b1, C);
    check("b2b8_strobes", 32'(strobes[0] - sb), 32'd2);
    check("0f_data",      cap_data[0], 32'h0F);
    check("0f_latency",   32'(strobe_cyc[0] - start_cyc), 32'd155);
    repeat (C) @(negedge clock);

    // 4-clock low glitch: no strobe, no busy, data held
    sb = strobes[0]; bb = busy_hi[0];
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 3 * C);
    check("glitch_strobes", 32'(strobes[0] - sb), 32'd0);
    check("glitch_busy",    32'(busy_hi[0] - bb), 32'd0);
    check("glitch_data",    32'(if8.data_out), 32'h0F);

    // stop bit low, then line held low for 3 more bit times
    sb = strobes[0];
    send_frame(0, 32'h3C, 8, -1, 1, 1'b0, 4 * C);
    check("3c_strobes", 32'(strobes[0] - sb), 32'd1);
    check("3c_data",    cap_data[0], 32'h3C);
    check("3c_ferr",    32'(cap_fe[0]), 32'h1);
    check("3c_hold_ferr", 32'(if8.framing_error), 32'h1);
    repeat (2 * C) @(negedge clock);
    check("hold_no_frame", 32'(strobes[0] - sb), 32'd1);
    send_frame(0, 32'h11, 8, -1, 1, 1'b1, C);
    check("11_data", cap_data[0], 32'h11);
    check("11_ferr", 32'(cap_fe[0]), 32'h0);
    check("11_strobes", 32'(strobes[0] - sb), 32'd2);
    repeat (C) @(negedge clock);

    // 8E1 0x07: even parity bit is 1; latency HALF + 10*C + 3 = 171
    send_frame(1, 32'h07, 8, 0, 1, 1'b1, C);
    check("par0_data",    cap_data[1], 32'h07);
    check("par0_perr",    32'(cap_pe[1]), 32'h1);
    check("par0_ferr",    32'(cap_fe[1]), 32'h0);
    check("par0_latency", 32'(strobe_cyc[1] - start_cyc), 32'd171);
    check("par0_hold",    32'(ifp.parity_error), 32'h1);
    send_frame(1, 32'h07, 8, 1, 1, 1'b1, C);
    check("par1_perr", 32'(cap_pe[1]), 32'h0);
    check("par1_data", cap_data[1], 32'h07);
    send_frame(1, 32'hB4, 8, 0, 1, 1'b1, C);
    check("b4_perr", 32'(cap_pe[1]), 32'h0);
    repeat (C) @(negedge clock);

    // reset in the middle of data bit 4 of a frame carrying 0x5A
    sb = strobes[0];
    db = 32'h5A;
    drive(0, 1'b0, C);
    for (int i = 0; i < 4; i++) drive(0, db[i], C);
    drive(0, db[4], HALF);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_data",  32'(if8.data_out), 32'h0);
    check("rstmid_busy",  32'(if8.busy), 32'h0);
    check("rstmid_valid", 32'(if8.data_valid), 32'h0);
    check("rstmid_ferr",  32'(if8.framing_error), 32'h0);
    repeat (3) @(negedge clock);
    ser[0] = 1'b1;
    reset_n = 1'b1;
    repeat (2 * C) @(negedge clock);
    check("rstmid_no_strobe", 32'(strobes[0] - sb), 32'd0);
    send_frame(0, 32'h5A, 8, -1, 1, 1'b1, C);
    check("5a_data",    cap_data[0], 32'h5A);
    check("5a_ferr",    32'(cap_fe[0]), 32'h0);
    check("5a_strobes", 32'(strobes[0] - sb), 32'd1);
    repeat (C) @(negedge clock);

    // 22N1 back-to-back; latency HALF + 23*C + 3 = 379
    sb = strobes[2];
    send_frame(2, 32'h2AAAAA, 22, -1, 1, 1'b1, C);
    check("w1_data",    cap_data[2], 32'h2AAAAA);
    check("w1_latency", 32'(strobe_cyc[2] - start_cyc), 32'd379);
    send_frame(2, 32'h155555, 22, -1, 1, 1'b1, C);
    check("w2_data",    cap_data[2], 32'h155555);
    check("w2_ferr",    32'(cap_fe[2]), 32'h0);
    check("w_strobes",  32'(strobes[2] - sb), 32'd2);

    // 22N2: latency HALF + 24*C + 3 = 395; second stop low flags framing error
    sb = strobes[3];
    send_frame(3, 32'h2AAAAA, 22, -1, 2, 1'b1, C);
    check("s2_data",    cap_data[3], 32'h2AAAAA);
    check("s2_ferr",    32'(cap_fe[3]), 32'h0);
    check("s2_latency", 32'(strobe_cyc[3] - start_cyc), 32'd395);
    send_frame(3, 32'h155555, 22, -1, 2, 1'b0, C);
    check("s2b_data",    cap_data[3], 32'h155555);
    check("s2b_ferr",    32'(cap_fe[3]), 32'h1);
    check("s2_strobes",  32'(strobes[3] - sb), 32'd2);
    repeat (2 * C) @(negedge clock);

    for (int k = 0; k < 4; k++) begin
      check($sformatf("dv_one_cycle_%0d", k), 32'(dbl[k]), 32'd0);
      check($sformatf("data_stable_%0d", k), 32'(silent[k]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
